palette_write_seq: RTL and testbench
====================================

# palette_write_seq

Palette write sequencer sitting directly upstream of the palette RAMs (the 256x8 R/B RAM and its companion G RAM). It turns CPU writes to the palette pointer (R#16) and palette data port (#2) into single-cycle RAM write strobes, assembling the two-byte 0RRR0BBB / 00000GGG sequence and auto-incrementing the pointer. After reset it loads the 16-entry default palette into both RAMs before accepting CPU traffic.

## Interface

- INIT_ON_RESET, 1, 1 = run the 16-cycle default-palette load after reset; 0 = go straight to idle.
- CLK  in  1  system clock; all logic on rising edge.
- RESET_N  in  1  one clock; reset is synchronous and active-low.
- PTR_WE  in  1  one-cycle strobe: CPU write to R#16.
- PTR_DATA  in  4  new palette pointer, valid with PTR_WE.
- PORT_WE  in  1  one-cycle strobe: CPU write to port #2.
- PORT_DATA  in  8  port #2 byte, valid with PORT_WE.
- PAL_ADR  out  8  RAM address, {4'h0, pointer}; shared by both RAMs.
- RB_WE  out  1  R/B RAM write enable.
- RB_DBO  out  8  R/B data, 0RRR0BBB.
- G_WE  out  1  G RAM write enable.
- G_DBO  out  8  G data, 00000GGG.
- BUSY  out  1  high while default load runs; CPU strobes ignored.

## Operation

- All outputs registered. Reset values: RB_WE=0, G_WE=0, PAL_ADR=8'h00, RB_DBO=8'h00, G_DBO=8'h00, BUSY=INIT_ON_RESET; internal pointer=0, byte phase=FIRST, latch=0.
- States: INIT, FIRST, SECOND.
- INIT (entered on reset if INIT_ON_RESET=1): each cycle writes entry k=0..15, RB_WE=G_WE=1, PAL_ADR=k. RB defaults 00,00,11,33,26,37,52,27,62,63,52,63,11,55,55,77; G defaults 00,00,05,06,02,03,02,06,02,03,05,06,04,02,05,07. After k=15 -> FIRST, BUSY=0, pointer=0. PTR_WE/PORT_WE in INIT are dropped, not queued.
- FIRST: PORT_WE latches PORT_DATA & 8'h77 -> SECOND. No RAM write.
- SECOND: PORT_WE commits: RB_WE=G_WE=1, PAL_ADR={4'h0,ptr}, RB_DBO=latch, G_DBO={5'b0,PORT_DATA[2:0]}; pointer <= ptr+1 mod 16 (15 wraps to 0) -> FIRST.
- PTR_WE (FIRST or SECOND): pointer <= PTR_DATA, phase -> FIRST, any pending first byte discarded. No RAM write.
- PTR_WE and PORT_WE in the same cycle: PTR_WE wins, PORT_WE dropped.
- Unused bits (RB bits 7,3; G bits 7:3) always written 0.
- RB_WE and G_WE always assert together; never asserted outside INIT or a SECOND-phase commit.
- RESET_N low in any state (including mid-INIT or in SECOND): next edge forces reset values; an INIT in progress restarts from k=0.

## Timing

- Strobe sampled at edge n -> WE high in cycle n..n+1 with address/data stable -> RAM captures at edge n+1. Total latency strobe-to-RAM-content: 2 edges.
- WE is exactly one cycle wide per commit; deasserts at next edge unless a new commit occurs.
- Back-to-back PORT_WE every cycle supported: one commit per two strobes, pointer advances once per commit.
- INIT: BUSY high from reset release for 16 cycles; BUSY falls on the edge that registers the entry-15 write completing (first cycle after WE for entry 15 is sampled). First CPU strobe accepted the cycle BUSY is low.
- PTR_WE effect visible on PAL_ADR at the next commit; pointer update takes one edge.

## Test plan

- Reset with INIT_ON_RESET=1 -> 16 consecutive cycles RB_WE=G_WE=1, PAL_ADR 0..15, entry 4 RB=8'h26 G=8'h02, entry 15 RB=8'h77 G=8'h07; then BUSY=0, WE=0.
- PTR_WE 4'h5, PORT_WE 8'hF7 then 8'hFD -> single write PAL_ADR=8'h05, RB_DBO=8'h77, G_DBO=8'h05; next commit targets 8'h06.
- Pointer 4'hF, two full pairs -> writes at 8'h0F then 8'h00 (wrap).
- PORT_WE 8'h12, then PTR_WE 4'h3, then PORT_WE 8'h44, 8'h01 -> one write at 8'h03, RB=8'h44, G=8'h01; 8'h12 never written.
- PTR_WE and PORT_WE same cycle in SECOND -> no write, phase FIRST, pointer=PTR_DATA.
- RESET_N low for one cycle during INIT entry 8 -> WE low next cycle, INIT restarts at 0, BUSY stays high 16 more cycles; CPU strobes during INIT produce no writes.

Source files
------------

// File: rtl/palette_write_seq.sv
// Palette write sequencer: turns pointer/port CPU strobes into paired
// R/B and G RAM write strobes, after an optional 16-entry default load.
module palette_write_seq #(
    parameter bit INIT_ON_RESET = 1'b1
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       PTR_WE,
    input  logic [3:0] PTR_DATA,
    input  logic       PORT_WE,
    input  logic [7:0] PORT_DATA,
    output logic [7:0] PAL_ADR,
    output logic       RB_WE,
    output logic [7:0] RB_DBO,
    output logic       G_WE,
    output logic [7:0] G_DBO,
    output logic       BUSY
);

    typedef enum logic [1:0] {
        S_INIT,
        S_FIRST,
        S_SECOND
    } state_t;

    state_t     state_q;
    logic [4:0] k_q;
    logic [3:0] ptr_q;
    logic [7:0] lat_q;
    logic [7:0] adr_q;
    logic [7:0] rb_q;
    logic [7:0] g_q;
    logic       we_q;
    logic       busy_q;

    function automatic logic [7:0] rb_def(input logic [3:0] k);
        case (k)
            4'd0:    return 8'h00;
            4'd1:    return 8'h00;
            4'd2:    return 8'h11;
            4'd3:    return 8'h33;
            4'd4:    return 8'h26;
            4'd5:    return 8'h37;
            4'd6:    return 8'h52;
            4'd7:    return 8'h27;
            4'd8:    return 8'h62;
            4'd9:    return 8'h63;
            4'd10:   return 8'h52;
            4'd11:   return 8'h63;
            4'd12:   return 8'h11;
            4'd13:   return 8'h55;
            4'd14:   return 8'h55;
            default: return 8'h77;
        endcase
    endfunction

    function automatic logic [2:0] g_def(input logic [3:0] k);
        case (k)
            4'd0:    return 3'd0;
            4'd1:    return 3'd0;
            4'd2:    return 3'd5;
            4'd3:    return 3'd6;
            4'd4:    return 3'd2;
            4'd5:    return 3'd3;
            4'd6:    return 3'd2;
            4'd7:    return 3'd6;
            4'd8:    return 3'd2;
            4'd9:    return 3'd3;
            4'd10:   return 3'd5;
            4'd11:   return 3'd6;
            4'd12:   return 3'd4;
            4'd13:   return 3'd2;
            4'd14:   return 3'd5;
            default: return 3'd7;
        endcase
    endfunction

    // k_q runs to 16 so the entry-15 write cycle still reports BUSY.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q <= INIT_ON_RESET ? S_INIT : S_FIRST;
            k_q     <= 5'd0;
            ptr_q   <= 4'd0;
            lat_q   <= 8'h00;
            we_q    <= 1'b0;
            adr_q   <= 8'h00;
            rb_q    <= 8'h00;
            g_q     <= 8'h00;
            busy_q  <= INIT_ON_RESET;
        end else begin
            we_q <= 1'b0;
            case (state_q)
                S_INIT: begin
                    if (k_q[4]) begin
                        state_q <= S_FIRST;
                        busy_q  <= 1'b0;
                        ptr_q   <= 4'd0;
                    end else begin
                        we_q  <= 1'b1;
                        adr_q <= {4'h0, k_q[3:0]};
                        rb_q  <= rb_def(k_q[3:0]);
                        g_q   <= {5'b0, g_def(k_q[3:0])};
                        k_q   <= k_q + 5'd1;
                    end
                end
                S_FIRST: begin
                    if (PTR_WE) begin
                        ptr_q <= PTR_DATA;
                    end else if (PORT_WE) begin
                        lat_q   <= PORT_DATA & 8'h77;
                        state_q <= S_SECOND;
                    end
                end
                S_SECOND: begin
                    if (PTR_WE) begin
                        ptr_q   <= PTR_DATA;
                        state_q <= S_FIRST;
                    end else if (PORT_WE) begin
                        we_q    <= 1'b1;
                        adr_q   <= {4'h0, ptr_q};
                        rb_q    <= lat_q;
                        g_q     <= {5'b0, PORT_DATA[2:0]};
                        ptr_q   <= ptr_q + 4'd1;
                        state_q <= S_FIRST;
                    end
                end
                default: state_q <= S_FIRST;
            endcase
        end
    end

    assign PAL_ADR = adr_q;
    assign RB_WE   = we_q;
    assign G_WE    = we_q;
    assign RB_DBO  = rb_q;
    assign G_DBO   = g_q;
    assign BUSY    = busy_q;

endmodule

// File: tb/tb_palette_write_seq.sv
// Bench for palette_write_seq: per-cycle behavioural model plus
// directed literal checks of the logged RAM writes.
module tb_palette_write_seq;

    logic       CLK = 1'b0;
    logic       RESET_N;
    logic       PTR_WE;
    logic [3:0] PTR_DATA;
    logic       PORT_WE;
    logic [7:0] PORT_DATA;
    logic [7:0] PAL_ADR;
    logic       RB_WE;
    logic [7:0] RB_DBO;
    logic       G_WE;
    logic [7:0] G_DBO;
    logic       BUSY;

    int errors = 0;
    int checks = 0;

    palette_write_seq #(.INIT_ON_RESET(1'b1)) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .PTR_WE(PTR_WE), .PTR_DATA(PTR_DATA),
        .PORT_WE(PORT_WE), .PORT_DATA(PORT_DATA),
        .PAL_ADR(PAL_ADR), .RB_WE(RB_WE), .RB_DBO(RB_DBO),
        .G_WE(G_WE), .G_DBO(G_DBO), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    logic [7:0] rbdef [16] = '{8'h00, 8'h00, 8'h11, 8'h33, 8'h26, 8'h37,
        8'h52, 8'h27, 8'h62, 8'h63, 8'h52, 8'h63, 8'h11, 8'h55, 8'h55, 8'h77};
    logic [7:0] gdef [16] = '{8'h00, 8'h00, 8'h05, 8'h06, 8'h02, 8'h03,
        8'h02, 8'h06, 8'h02, 8'h03, 8'h05, 8'h06, 8'h04, 8'h02, 8'h05, 8'h07};

    // Reference model: INIT cycles left, pointer, optional pending first byte.
    int         m_init_left = 0;
    logic [3:0] m_ptr = 4'd0;
    bit         m_pending = 1'b0;
    logic [7:0] m_first = 8'h00;
    logic       e_we = 1'b0;
    logic       e_busy = 1'b1;
    logic [7:0] e_adr = 8'h00;
    logic [7:0] e_rb = 8'h00;
    logic [7:0] e_g = 8'h00;

    always @(posedge CLK) begin
        e_we = 1'b0;
        if (!RESET_N) begin
            m_init_left = 17;
            m_ptr = 4'd0;
            m_pending = 1'b0;
            m_first = 8'h00;
            e_adr = 8'h00;
            e_rb = 8'h00;
            e_g = 8'h00;
            e_busy = 1'b1;
        end else if (m_init_left > 0) begin
            if (m_init_left > 1) begin
                e_we = 1'b1;
                e_adr = 8'(17 - m_init_left);
                e_rb = rbdef[17 - m_init_left];
                e_g = gdef[17 - m_init_left];
            end else begin
                e_busy = 1'b0;
                m_ptr = 4'd0;
            end
            m_init_left--;
        end else if (PTR_WE) begin
            m_ptr = PTR_DATA;
            m_pending = 1'b0;
        end else if (PORT_WE && !m_pending) begin
            m_first = PORT_DATA & 8'h77;
            m_pending = 1'b1;
        end else if (PORT_WE) begin
            e_we = 1'b1;
            e_adr = {4'h0, m_ptr};
            e_rb = m_first;
            e_g = {5'b0, PORT_DATA[2:0]};
            m_ptr = 4'((m_ptr + 1) % 16);
            m_pending = 1'b0;
        end
    end

    always @(negedge CLK) begin
        checks++;
        if ({RB_WE, G_WE, BUSY, PAL_ADR, RB_DBO, G_DBO} !==
            {e_we, e_we, e_busy, e_adr, e_rb, e_g}) begin
            errors++;
            $display("FAIL cycle t=%0t: got we=%b/%b busy=%b adr=%h rb=%h g=%h required we=%b busy=%b adr=%h rb=%h g=%h",
                $time, RB_WE, G_WE, BUSY, PAL_ADR, RB_DBO, G_DBO,
                e_we, e_busy, e_adr, e_rb, e_g);
        end
    end

    logic [23:0] wlog[$];
    always @(posedge CLK) begin
        #1;
        if (RB_WE) wlog.push_back({PAL_ADR, RB_DBO, G_DBO});
    end

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, got, req);
        end
    endtask

    task automatic cyc(input logic pw, input logic [3:0] pd,
                       input logic dw, input logic [7:0] dd);
        PTR_WE = pw;
        PTR_DATA = pd;
        PORT_WE = dw;
        PORT_DATA = dd;
        @(negedge CLK);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 4'h0, 1'b0, 8'h00);
    endtask

    initial begin
        int bcnt;
        RESET_N = 1'b0;
        idle(3);
        chk("reset_busy", 32'(BUSY), 32'd1);
        chk("reset_we", 32'({RB_WE, G_WE}), 32'd0);
        chk("reset_adr_data", {8'h0, PAL_ADR, RB_DBO, G_DBO}, 32'd0);
        RESET_N = 1'b1;
        idle(20);
        chk("init_count", 32'(wlog.size()), 32'd16);
        if (wlog.size() == 16) begin
            chk("init_entry0", 32'(wlog[0]), 32'h000000);
            chk("init_entry4", 32'(wlog[4]), 32'h042602);
            chk("init_entry15", 32'(wlog[15]), 32'h0F7707);
        end
        chk("init_done_busy", 32'(BUSY), 32'd0);

        wlog.delete();
        cyc(1'b1, 4'h5, 1'b0, 8'h00);
        cyc(1'b0, 4'h0, 1'b1, 8'hF7);
        cyc(1'b0, 4'h0, 1'b1, 8'hFD);
        cyc(1'b0, 4'h0, 1'b1, 8'h00);
        cyc(1'b0, 4'h0, 1'b1, 8'h01);
        idle(2);
        chk("ptr5_count", 32'(wlog.size()), 32'd2);
        if (wlog.size() == 2) begin
            chk("ptr5_write", 32'(wlog[0]), 32'h057705);
            chk("ptr5_next", 32'(wlog[1]), 32'h060001);
        end

        wlog.delete();
        cyc(1'b1, 4'hF, 1'b0, 8'h00);
        cyc(1'b0, 4'h0, 1'b1, 8'h11);
        cyc(1'b0, 4'h0, 1'b1, 8'h01);
        cyc(1'b0, 4'h0, 1'b1, 8'hAA);
        cyc(1'b0, 4'h0, 1'b1, 8'hFA);
        idle(2);
        chk("wrap_count", 32'(wlog.size()), 32'd2);
        if (wlog.size() == 2) begin
            chk("wrap_first", 32'(wlog[0]), 32'h0F1101);
            chk("wrap_second", 32'(wlog[1]), 32'h002202);
        end

        wlog.delete();
        cyc(1'b0, 4'h0, 1'b1, 8'h12);
        cyc(1'b1, 4'h3, 1'b0, 8'h00);
        cyc(1'b0, 4'h0, 1'b1, 8'h44);
        cyc(1'b0, 4'h0, 1'b1, 8'h01);
        idle(2);
        chk("discard_count", 32'(wlog.size()), 32'd1);
        if (wlog.size() == 1) chk("discard_write", 32'(wlog[0]), 32'h034401);

        wlog.delete();
        cyc(1'b0, 4'h0, 1'b1, 8'h33);
        cyc(1'b1, 4'h9, 1'b1, 8'h55);
        idle(2);
        chk("collide_nowrite", 32'(wlog.size()), 32'd0);
        cyc(1'b0, 4'h0, 1'b1, 8'h66);
        cyc(1'b0, 4'h0, 1'b1, 8'h02);
        idle(2);
        chk("collide_after", 32'(wlog.size()), 32'd1);
        if (wlog.size() == 1) chk("collide_write", 32'(wlog[0]), 32'h096602);

        RESET_N = 1'b0;
        idle(1);
        RESET_N = 1'b1;
        idle(9);
        RESET_N = 1'b0;
        idle(1);
        chk("midinit_we_low", 32'(RB_WE), 32'd0);
        RESET_N = 1'b1;
        wlog.delete();
        bcnt = 0;
        for (int i = 0; i < 16; i++) begin
            cyc(1'($urandom_range(0, 1)), 4'($urandom), 1'b1, 8'($urandom));
            if (BUSY) bcnt++;
        end
        for (int i = 0; i < 4; i++) begin
            idle(1);
            if (BUSY) bcnt++;
        end
        chk("restart_busy_cycles", 32'(bcnt), 32'd16);
        chk("restart_count", 32'(wlog.size()), 32'd16);
        if (wlog.size() == 16) begin
            chk("restart_entry0", 32'(wlog[0]), 32'h000000);
            chk("restart_entry8", 32'(wlog[8]), 32'h086202);
        end

        for (int i = 0; i < 3000; i++) begin
            RESET_N = ($urandom_range(0, 499) != 0);
            cyc(1'($urandom_range(0, 9) == 0), 4'($urandom),
                1'($urandom_range(0, 2) != 0), 8'($urandom));
        end
        RESET_N = 1'b1;
        idle(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
